// File: rtl/win_integrator_pkg.sv
// win_integrator_pkg: shared FSM state type and width helpers for win_integrator
package win_integrator_pkg;
  typedef enum logic [1:0] {IDLE, SKIP, ACCUM} state_t;
  function automatic int prod_w(input int in_w, input int gain);
    return in_w + $clog2(gain + 1);
  endfunction
  function automatic int cnt_w(input int skip_cycles, input int acc_cycles);
    int m;
    m = skip_cycles > acc_cycles ? skip_cycles : acc_cycles;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/win_integrator_if.sv
// win_integrator_if: sample/enable in, window result/status out; master drives en/x, slave is the integrator
interface win_integrator_if #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 13
);
  logic             en;
  logic [IN_W-1:0]  x;
  logic [ACC_W-1:0] y;
  logic             y_valid;
  logic             ovf;
  logic             busy;
  modport master (output en, x, input y, y_valid, ovf, busy);
  modport slave  (input en, x, output y, y_valid, ovf, busy);
endinterface

// File: rtl/win_seq.sv
// win_seq: skip/accumulate window sequencer producing acc_en, dump and abort strobes
module win_seq
  import win_integrator_pkg::*;
#(
  parameter int SKIP_CYCLES = 4,
  parameter int ACC_CYCLES  = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_acc_en,
  output logic o_dump,
  output logic o_abort,
  output logic o_busy
);
  localparam int CW = cnt_w(SKIP_CYCLES, ACC_CYCLES);
  localparam logic [CW-1:0] SKIP_LAST = CW'(SKIP_CYCLES - 1);
  localparam logic [CW-1:0] ACC_LAST = CW'(ACC_CYCLES - 1);
  localparam state_t RUN = SKIP_CYCLES == 0 ? ACCUM : SKIP;
  state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
    end
  always_comb begin
    w_state = IDLE;
    w_cnt = '0;
    o_acc_en = 1'b0;
    o_dump = 1'b0;
    o_abort = 1'b0;
    case (r_state)
      IDLE: w_state = i_en ? RUN : IDLE;
      SKIP: begin
        o_abort = !i_en;
        w_state = !i_en ? IDLE : r_cnt == SKIP_LAST ? ACCUM : SKIP;
        w_cnt = (!i_en || r_cnt == SKIP_LAST) ? '0 : r_cnt + CW'(1);
      end
      ACCUM: begin
        o_dump = r_cnt == ACC_LAST;
        o_abort = !i_en && !o_dump;
        o_acc_en = i_en && !o_dump;
        w_state = !i_en ? IDLE : o_dump ? RUN : ACCUM;
        w_cnt = (!i_en || o_dump) ? '0 : r_cnt + CW'(1);
      end
      default: w_state = IDLE;
    endcase
  end
  assign o_busy = r_state != IDLE;
endmodule

// File: rtl/win_integrator.sv
// win_integrator: windowed gain-scaled integrate-and-dump; WIN_INTEGRATOR_SAT_EN selects saturating accumulation with ovf
module win_integrator
  import win_integrator_pkg::*;
#(
  parameter int IN_W        = 4,
  parameter int GAIN        = 25,
  parameter int SKIP_CYCLES = 4,
  parameter int ACC_CYCLES  = 4,
  parameter int ACC_W       = 13
) (
  input logic i_clk,
  input logic i_rst_n,
  win_integrator_if.slave bus
);
  localparam int PW = prod_w(IN_W, GAIN);
  logic [PW-1:0] w_p;
  logic [ACC_W-1:0] r_acc, r_y, w_add;
  logic r_valid, r_ovf, r_sat, w_sat;
  logic w_acc_en, w_dump, w_abort, w_busy;
  win_seq #(.SKIP_CYCLES(SKIP_CYCLES), .ACC_CYCLES(ACC_CYCLES)) u_seq (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_en(bus.en),
    .o_acc_en(w_acc_en),
    .o_dump(w_dump),
    .o_abort(w_abort),
    .o_busy(w_busy)
  );
  assign w_p = PW'(GAIN) * PW'(bus.x);
`ifdef WIN_INTEGRATOR_SAT_EN
  logic [ACC_W:0] w_sum;
  assign w_sum = {1'b0, r_acc} + (ACC_W + 1)'(w_p);
  assign w_add = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
  assign w_sat = w_sum[ACC_W];
`else
  assign w_add = r_acc + ACC_W'(w_p);
  assign w_sat = 1'b0;
`endif
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_acc <= '0;
      r_y <= '0;
      r_valid <= 1'b0;
      r_ovf <= 1'b0;
      r_sat <= 1'b0;
    end else begin
      r_valid <= w_dump;
      if (w_dump) begin
        r_y <= w_add;
        r_ovf <= r_sat | w_sat;
        r_acc <= '0;
        r_sat <= 1'b0;
      end else if (w_acc_en) begin
        r_acc <= w_add;
        r_sat <= r_sat | w_sat;
      end else if (w_abort) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end
    end
  assign bus.y = r_y;
  assign bus.y_valid = r_valid;
  assign bus.ovf = r_ovf;
  assign bus.busy = w_busy;
endmodule

// File: tb/tb_win_integrator.sv
// tb_win_integrator: three-configuration self-checking bench against a window-timing reference model
module tb_win_integrator;
`ifdef WIN_INTEGRATOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    bit     act;
    int     n;
    longint sum;
    longint y;
    bit     v;
    bit     ovf;
  } mdl_t;
  typedef struct {
    int a, b, c, d;
    int y0;
    int x1;
    int y1;
    bit o1;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  mdl_t m0, m1, m2;
  vec_t tbl[5];
  win_integrator_if #(.IN_W(4), .ACC_W(13)) b0 ();
  win_integrator_if #(.IN_W(4), .ACC_W(10)) b1 ();
  win_integrator_if #(.IN_W(4), .ACC_W(13)) b2 ();
  win_integrator u0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0));
  win_integrator #(.ACC_W(10)) u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));
  win_integrator #(.SKIP_CYCLES(0), .ACC_CYCLES(1)) u2 (.i_clk(clk), .i_rst_n(rst_n), .bus(b2));
  always #5 clk = ~clk;
  function automatic void mstep(inout mdl_t m, input bit rn, input bit en, input int x,
                                input int s, input int a, input int w);
    longint mx;
    int pos;
    mx = (longint'(1) << w) - 1;
    if (!rn) begin
      m.act = 0; m.n = 0; m.sum = 0; m.y = 0; m.v = 0; m.ovf = 0;
      return;
    end
    m.v = 0;
    if (!m.act) begin
      if (en) begin
        m.act = 1; m.n = 0; m.sum = 0;
      end
      return;
    end
    m.n++;
    pos = ((m.n - 1) % (s + a)) + 1;
    if (pos != s + a && !en) begin
      m.act = 0; m.sum = 0;
      return;
    end
    if (pos > s) m.sum += 25 * x;
    if (pos == s + a) begin
      m.v = 1;
      m.y = SAT ? (m.sum > mx ? mx : m.sum) : m.sum % (mx + 1);
      m.ovf = SAT && m.sum > mx;
      m.sum = 0;
      if (!en) m.act = 0;
    end
  endfunction
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask
  task automatic cmp(input string t, input mdl_t m, input longint y, input bit v, input bit o, input bit b);
    chk({t, "_y"}, y, m.y);
    chk({t, "_valid"}, longint'(v), longint'(m.v));
    chk({t, "_ovf"}, longint'(o), longint'(m.ovf));
    chk({t, "_busy"}, longint'(b), longint'(m.act));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    mstep(m0, rst_n, b0.en, int'(b0.x), 4, 4, 13);
    mstep(m1, rst_n, b1.en, int'(b1.x), 4, 4, 10);
    mstep(m2, rst_n, b2.en, int'(b2.x), 0, 1, 13);
    cmp("d0", m0, longint'(b0.y), b0.y_valid, b0.ovf, b0.busy);
    cmp("d1", m1, longint'(b1.y), b1.y_valid, b1.ovf, b1.busy);
    cmp("d2", m2, longint'(b2.y), b2.y_valid, b2.ovf, b2.busy);
  endtask
  initial begin
    int xv[4];
    int cnt;
    tbl[0] = '{10, 10, 10, 10, 1000, 15, SAT ? 1023 : 476, SAT};
    tbl[1] = '{10, 5, 12, 1, 700, 1, 100, 1'b0};
    tbl[2] = '{13, 7, 9, 2, 775, 15, SAT ? 1023 : 476, SAT};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 1'b0};
    tbl[4] = '{15, 15, 15, 15, 1500, 2, 200, 1'b0};
    b0.en = 0; b1.en = 0; b2.en = 0;
    b0.x = 0; b1.x = 0; b2.x = 0;
    rst_n = 0;
    tick();
    tick();
    chk("rst_y", longint'(b0.y), 0);
    chk("rst_valid", longint'(b0.y_valid), 0);
    chk("rst_ovf", longint'(b0.ovf), 0);
    chk("rst_busy", longint'(b0.busy), 0);
    rst_n = 1;
    b0.en = 1; b1.en = 1; b2.en = 1;
    b2.x = 3;
    tick();
    for (int r = 0; r < 5; r++) begin
      xv = '{tbl[r].a, tbl[r].b, tbl[r].c, tbl[r].d};
      b1.x = 4'(tbl[r].x1);
      for (int k = 0; k < 8; k++) begin
        b0.x = k < 4 ? 4'($urandom_range(0, 15)) : 4'(xv[k-4]);
        tick();
        chk("s0_valid", longint'(b2.y_valid), 1);
        chk("s0_y", longint'(b2.y), 75);
      end
      chk("tbl_valid0", longint'(b0.y_valid), 1);
      chk("tbl_y0", longint'(b0.y), tbl[r].y0);
      chk("tbl_y1", longint'(b1.y), tbl[r].y1);
      chk("tbl_ovf1", longint'(b1.ovf), longint'(tbl[r].o1));
    end
    for (int k = 0; k < 4; k++) tick();
    b0.x = 5;
    tick();
    b0.en = 0;
    tick();
    chk("abort_busy", longint'(b0.busy), 0);
    chk("abort_valid", longint'(b0.y_valid), 0);
    chk("abort_y", longint'(b0.y), 1500);
    for (int k = 0; k < 3; k++) tick();
    b0.en = 1;
    b0.x = 2;
    for (int k = 0; k < 9; k++) tick();
    chk("reen_valid", longint'(b0.y_valid), 1);
    chk("reen_y", longint'(b0.y), 200);
    for (int k = 0; k < 6; k++) tick();
    rst_n = 0;
    tick();
    chk("mid_rst_y", longint'(b0.y), 0);
    chk("mid_rst_valid", longint'(b0.y_valid), 0);
    chk("mid_rst_ovf", longint'(b0.ovf), 0);
    chk("mid_rst_busy", longint'(b0.busy), 0);
    rst_n = 1;
    cnt = 0;
    for (int k = 0; k < 20 && !b0.y_valid; k++) begin
      tick();
      cnt++;
    end
    chk("rst_first_dump", cnt, 9);
    chk("rst_first_y", longint'(b0.y), 200);
    for (int k = 0; k < 600; k++) begin
      rst_n = $urandom_range(0, 199) != 0;
      b0.en = $urandom_range(0, 15) != 0;
      b1.en = $urandom_range(0, 15) != 0;
      b2.en = $urandom_range(0, 15) != 0;
      b0.x = 4'($urandom_range(0, 15));
      b1.x = 4'($urandom_range(0, 15));
      b2.x = 4'($urandom_range(0, 15));
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
